// File: rtl/pll_lock_detector_if.sv
// pll_lock_detector_if: sample and status bundle between the ADPLL error path
// and the lock detector.
// Optional feature macro: PLL_LOCK_PEAK_HOLD_EN adds the peak_abs_o status field.
interface pll_lock_detector_if #(
  parameter int ERR_W        = 8,
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 4
);
  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic                    enable_i;
  logic                    err_valid_i;
  logic signed [ERR_W-1:0] err_i;
  logic                    locked_o;
  logic [1:0]              state_o;
  logic                    lock_lost_o;
  logic [CW-1:0]           run_cnt_o;
`ifdef PLL_LOCK_PEAK_HOLD_EN
  logic [ERR_W-2:0]        peak_abs_o;

  modport master (
    output enable_i, err_valid_i, err_i,
    input  locked_o, state_o, lock_lost_o, run_cnt_o, peak_abs_o
  );

  modport slave (
    input  enable_i, err_valid_i, err_i,
    output locked_o, state_o, lock_lost_o, run_cnt_o, peak_abs_o
  );
`else
  modport master (
    output enable_i, err_valid_i, err_i,
    input  locked_o, state_o, lock_lost_o, run_cnt_o
  );

  modport slave (
    input  enable_i, err_valid_i, err_i,
    output locked_o, state_o, lock_lost_o, run_cnt_o
  );
`endif

endinterface

// File: rtl/pll_lock_detector.sv
// pll_lock_detector: hysteretic lock qualifier for the ADPLL phase error.
// N consecutive in-window samples declare lock, M consecutive out-of-window
// samples (through HOLDOVER) declare loss and fire a one-cycle lock_lost pulse.
// Optional feature macro: PLL_LOCK_PEAK_HOLD_EN tracks the peak |error| seen
// while locked.
module pll_lock_detector #(
  parameter int ERR_W        = 8,
  parameter int LOCK_THRESH  = 2,
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  pll_lock_detector_if.slave bus
);

  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    run_cnt_reg, run_cnt_next;
  logic             lock_lost_reg, lock_lost_next;
  logic [ERR_W-1:0] err_bits;
  logic [ERR_W-2:0] abs_val;
  logic [CW-1:0]    cnt_inc;
  logic             accept;
  logic             in_win;
`ifdef PLL_LOCK_PEAK_HOLD_EN
  logic [ERR_W-2:0] peak_reg, peak_next;
  logic [ERR_W-2:0] peak_upd;
`endif

  assign accept   = bus.enable_i & bus.err_valid_i;
  assign err_bits = bus.err_i;
  // The counter is only incremented below its terminal value, so it cannot wrap.
  assign cnt_inc  = run_cnt_reg + 1'b1;

  // Magnitude of the sample; the most-negative code saturates to the largest
  // positive magnitude instead of wrapping back to a negative value.
  always_comb begin
    if (!err_bits[ERR_W-1]) begin
      abs_val = err_bits[ERR_W-2:0];
    end else if (err_bits[ERR_W-2:0] == '0) begin
      abs_val = '1;
    end else begin
      abs_val = (~err_bits[ERR_W-2:0]) + 1'b1;
    end
    in_win = (int'({1'b0, abs_val}) <= LOCK_THRESH);
  end

`ifdef PLL_LOCK_PEAK_HOLD_EN
  assign peak_upd = (abs_val > peak_reg) ? abs_val : peak_reg;
`endif

  // State register: state, run counter, loss pulse and optional peak.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= UNLOCKED;
      run_cnt_reg   <= '0;
      lock_lost_reg <= 1'b0;
`ifdef PLL_LOCK_PEAK_HOLD_EN
      peak_reg      <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      run_cnt_reg   <= run_cnt_next;
      lock_lost_reg <= lock_lost_next;
`ifdef PLL_LOCK_PEAK_HOLD_EN
      peak_reg      <= peak_next;
`endif
    end
  end

  // Next-state logic: everything holds unless a sample is accepted; the loss
  // pulse defaults low so it always clears after one cycle, even if disabled.
  always_comb begin
    state_next     = state_reg;
    run_cnt_next   = run_cnt_reg;
    lock_lost_next = 1'b0;
`ifdef PLL_LOCK_PEAK_HOLD_EN
    peak_next      = peak_reg;
`endif
    if (accept) begin
      case (state_reg)
        UNLOCKED: begin
          if (in_win) begin
            if (LOCK_COUNT == 1) begin
              state_next   = LOCKED;
              run_cnt_next = '0;
`ifdef PLL_LOCK_PEAK_HOLD_EN
              peak_next    = '0;
`endif
            end else begin
              state_next   = ACQUIRE;
              run_cnt_next = CW'(1);
            end
          end else begin
            run_cnt_next = '0;
          end
        end
        ACQUIRE: begin
          if (in_win) begin
            if (cnt_inc == LOCK_LAST) begin
              state_next   = LOCKED;
              run_cnt_next = '0;
`ifdef PLL_LOCK_PEAK_HOLD_EN
              peak_next    = '0;
`endif
            end else begin
              run_cnt_next = cnt_inc;
            end
          end else begin
            state_next   = UNLOCKED;
            run_cnt_next = '0;
          end
        end
        LOCKED: begin
`ifdef PLL_LOCK_PEAK_HOLD_EN
          peak_next = peak_upd;
`endif
          if (!in_win) begin
            if (UNLOCK_COUNT == 1) begin
              state_next     = UNLOCKED;
              run_cnt_next   = '0;
              lock_lost_next = 1'b1;
            end else begin
              state_next   = HOLDOVER;
              run_cnt_next = CW'(1);
            end
          end else begin
            run_cnt_next = '0;
          end
        end
        HOLDOVER: begin
`ifdef PLL_LOCK_PEAK_HOLD_EN
          peak_next = peak_upd;
`endif
          if (in_win) begin
            state_next   = LOCKED;
            run_cnt_next = '0;
          end else if (cnt_inc == UNLOCK_LAST) begin
            state_next     = UNLOCKED;
            run_cnt_next   = '0;
            lock_lost_next = 1'b1;
          end else begin
            run_cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next   = UNLOCKED;
          run_cnt_next = '0;
        end
      endcase
    end
  end

  // Output decode: all outputs come straight from registered state.
  always_comb begin
    bus.state_o     = state_reg;
    bus.locked_o    = (state_reg == LOCKED) || (state_reg == HOLDOVER);
    bus.lock_lost_o = lock_lost_reg;
    bus.run_cnt_o   = run_cnt_reg;
`ifdef PLL_LOCK_PEAK_HOLD_EN
    bus.peak_abs_o  = peak_reg;
`endif
  end

endmodule

// File: tb/tb_pll_lock_detector.sv
// tb_pll_lock_detector: directed bench for pll_lock_detector with a
// scoreboard queue of expected registered outputs per driven step.
module tb_pll_lock_detector;

  localparam int ERR_W        = 8;
  localparam int LOCK_THRESH  = 2;
  localparam int LOCK_COUNT   = 64;
  localparam int UNLOCK_COUNT = 4;

  localparam logic [1:0] S_UNL = 2'd0;
  localparam logic [1:0] S_ACQ = 2'd1;
  localparam logic [1:0] S_LCK = 2'd2;
  localparam logic [1:0] S_HLD = 2'd3;

  typedef struct {
    logic [1:0] state;
    int         cnt;
    logic       locked;
    logic       lost;
    int         peak;
    string      tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  pll_lock_detector_if #(
    .ERR_W(ERR_W), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT)
  ) bus ();

  pll_lock_detector #(
    .ERR_W(ERR_W), .LOCK_THRESH(LOCK_THRESH),
    .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Compare current DUT outputs against one expected record.
  task automatic compare(input exp_t e);
    check({e.tag, ".state"},   32'(bus.state_o),     32'(e.state));
    check({e.tag, ".run_cnt"}, 32'(bus.run_cnt_o),   32'(e.cnt));
    check({e.tag, ".locked"},  32'(bus.locked_o),    32'(e.locked));
    check({e.tag, ".lost"},    32'(bus.lock_lost_o), 32'(e.lost));
`ifdef PLL_LOCK_PEAK_HOLD_EN
    check({e.tag, ".peak"},    32'(bus.peak_abs_o),  32'(e.peak));
`endif
  endtask

  function automatic exp_t mk(input logic [1:0] s, input int cnt, input logic lost,
                              input int pk, input string tag);
    exp_t e;
    e.state  = s;
    e.cnt    = cnt;
    e.locked = (s == S_LCK) || (s == S_HLD);
    e.lost   = lost;
    e.peak   = pk;
    e.tag    = tag;
    return e;
  endfunction

  // Drive one cycle of inputs, queue the expected result, then compare it
  // #1 after the edge that registers it.
  task automatic step(input logic en, input logic vld, input int err,
                      input logic [1:0] s, input int cnt, input logic lost,
                      input int pk, input string tag);
    exp_t e;
    bus.enable_i    = en;
    bus.err_valid_i = vld;
    bus.err_i       = ERR_W'(err);
    sb.push_back(mk(s, cnt, lost, pk, tag));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("step %-12s en=%0b vld=%0b err=%0d -> state=%0d cnt=%0d locked=%0b lost=%0b",
             tag, en, vld, err, bus.state_o, bus.run_cnt_o, bus.locked_o, bus.lock_lost_o);
    compare(e);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n           = 1'b0;
    bus.enable_i    = 1'b0;
    bus.err_valid_i = 1'b0;
    bus.err_i       = '0;
    repeat (2) @(posedge clk);
    #1;
    compare(mk(S_UNL, 0, 1'b0, 0, "reset"));
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Out-of-window in UNLOCKED stays put.
    step(1, 1, 3, S_UNL, 0, 0, 0, "unl_out");

    // Acquire abort: 30 in-window, an ignored non-strobe, then +3.
    for (int i = 1; i <= 30; i++) step(1, 1, 1, S_ACQ, i, 0, 0, "acq_a");
    step(1, 0, 50, S_ACQ, 30, 0, 0, "no_strobe");
    step(1, 1, 3, S_UNL, 0, 0, 0, "abort");

    // Full acquisition on the negative window edge.
    for (int i = 1; i <= LOCK_COUNT; i++) begin
      if (i < LOCK_COUNT) step(1, 1, -2, S_ACQ, i, 0, 0, "acq_b");
      else                step(1, 1, -2, S_LCK, 0, 0, 0, "lock_b");
    end

    // Positive window edge keeps lock.
    step(1, 1, 2, S_LCK, 0, 0, 2, "lck_edge");

    // Holdover recovery.
    for (int i = 1; i <= 3; i++) step(1, 1, 5, S_HLD, i, 0, 5, "hold");
    step(1, 1, 0, S_LCK, 0, 0, 5, "recover");

    // Freeze in LOCKED; the first strobe coincides with enable falling.
    step(0, 1, 50, S_LCK, 0, 0, 5, "frz_edge");
    for (int i = 0; i < 99; i++) step(0, 1, 50, S_LCK, 0, 0, 5, "frz_lck");

    // Freeze in HOLDOVER must also hold the counter.
    step(1, 1, 5, S_HLD, 1, 0, 5, "hold1");
    for (int i = 0; i < 10; i++) step(0, 1, 50, S_HLD, 1, 0, 5, "frz_hld");
    step(1, 1, 0, S_LCK, 0, 0, 5, "recover2");

    // Loss with the saturating most-negative code.
    for (int i = 1; i <= 3; i++) step(1, 1, -128, S_HLD, i, 0, 127, "loss_h");
    step(1, 1, -128, S_UNL, 0, 1, 127, "loss");
    step(0, 0, 0, S_UNL, 0, 0, 127, "lost_clr");

    // Relock; peak clears on entry to LOCKED.
    for (int i = 1; i <= LOCK_COUNT; i++) begin
      if (i < LOCK_COUNT) step(1, 1, 0, S_ACQ, i, 0, 127, "acq_c");
      else                step(1, 1, 0, S_LCK, 0, 0, 0, "lock_c");
    end
    step(1, 1, -3, S_HLD, 1, 0, 3, "hold_r");

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    compare(mk(S_UNL, 0, 1'b0, 0, "async_rst"));
    @(posedge clk);
    #1;
    compare(mk(S_UNL, 0, 1'b0, 0, "rst_held"));
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 1, 1, S_ACQ, 1, 0, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
